// File: rtl/vga_text_cmd_engine.sv
// Text command engine: turns register writes into character-buffer writes.
// Commands are queued in a small FIFO and drained by an IDLE/WRITE/CLEAR FSM.
module vga_text_cmd_engine #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              buf_valid,
    input  logic              buf_ready,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [15:0]       buf_data,
    output logic              busy,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              err_drop
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [6:0]        COL_MAX   = 7'(COLS - 1);
    localparam logic [4:0]        ROW_MAX   = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR
    } state_t;

    // Entry: bit16 = 1 for SETCUR, else PUT; bits 15:0 hold {attr,char} or cursor fields.
    logic [16:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;

    state_t            r_state;
    logic [7:0]        r_attr;
    logic              r_autoinc;
    logic              r_clear_pend;
    logic              r_err_drop;
    logic              r_busy;
    logic [6:0]        r_cur_col;
    logic [4:0]        r_cur_row;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [15:0]       r_buf_data;

    logic              w_empty;
    logic              w_full;
    logic              w_ctrl;
    logic              w_push_req;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic [16:0]       w_push_entry;
    logic [16:0]       w_head;
    logic [6:0]        w_set_col;
    logic [4:0]        w_set_row;
    logic [6:0]        w_adv_col;
    logic [4:0]        w_adv_row;
    logic [ADDR_W-1:0] w_put_addr;
    logic              w_unused_wdata;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

    assign w_ctrl     = cfg_wr && (cfg_addr == 2'd0);
    assign w_push_req = cfg_wr && ((cfg_addr == 2'd1) || (cfg_addr == 2'd2));
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_pop      = (r_state == S_IDLE) && !r_clear_pend && !w_empty;

    assign w_push_entry = (cfg_addr == 2'd2) ? {1'b1, 3'b000, cfg_wdata[12:0]}
                                             : {1'b0, r_attr, cfg_wdata[7:0]};
    assign w_head       = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_unused_wdata = ^cfg_wdata[31:13];

    assign w_set_col = (w_head[6:0]  > COL_MAX) ? COL_MAX : w_head[6:0];
    assign w_set_row = (w_head[12:8] > ROW_MAX) ? ROW_MAX : w_head[12:8];

    always_comb begin
        w_adv_col = r_cur_col + 7'd1;
        w_adv_row = r_cur_row;
        if (r_cur_col == COL_MAX) begin
            w_adv_col = 7'd0;
            w_adv_row = (r_cur_row == ROW_MAX) ? 5'd0 : r_cur_row + 5'd1;
        end
    end

    assign w_put_addr = ADDR_W'(r_cur_row) * ADDR_W'(COLS) + ADDR_W'(r_cur_col);

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_entry;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_state      <= S_IDLE;
            r_attr       <= 8'h07;
            r_autoinc    <= 1'b1;
            r_clear_pend <= 1'b0;
            r_err_drop   <= 1'b0;
            r_busy       <= 1'b0;
            r_cur_col    <= 7'd0;
            r_cur_row    <= 5'd0;
            r_clr_cnt    <= '0;
            r_buf_valid  <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_data   <= 16'h0000;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            if (cfg_wr && (cfg_addr == 2'd3)) r_attr <= cfg_wdata[7:0];
            if (w_ctrl) r_autoinc <= cfg_wdata[1];

            if (w_drop) begin
                r_err_drop <= 1'b1;
            end else if (w_ctrl && cfg_wdata[2]) begin
                r_err_drop <= 1'b0;
            end

            r_busy <= (r_state != S_IDLE) || !w_empty || r_clear_pend;

            case (r_state)
                S_IDLE: begin
                    if (r_clear_pend) begin
                        r_clear_pend <= 1'b0;
                        r_clr_cnt    <= '0;
                        r_buf_valid  <= 1'b1;
                        r_buf_addr   <= '0;
                        r_buf_data   <= {r_attr, 8'h20};
                        r_state      <= S_CLEAR;
                    end else if (!w_empty) begin
                        if (w_head[16]) begin
                            r_cur_col <= w_set_col;
                            r_cur_row <= w_set_row;
                        end else begin
                            r_buf_valid <= 1'b1;
                            r_buf_addr  <= w_put_addr;
                            r_buf_data  <= w_head[15:0];
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (buf_ready) begin
                        r_buf_valid <= 1'b0;
                        if (r_autoinc) begin
                            r_cur_col <= w_adv_col;
                            r_cur_row <= w_adv_row;
                        end
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (buf_ready) begin
                        if (r_clr_cnt == LAST_CELL) begin
                            r_buf_valid <= 1'b0;
                            r_cur_col   <= 7'd0;
                            r_cur_row   <= 5'd0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_clr_cnt  <= r_clr_cnt + 1'b1;
                            r_buf_addr <= r_clr_cnt + 1'b1;
                            r_buf_data <= {r_attr, 8'h20};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A clear request arriving while one is being started re-arms it.
            if (w_ctrl && cfg_wdata[0]) r_clear_pend <= 1'b1;
        end
    end

    assign buf_valid  = r_buf_valid;
    assign buf_addr   = r_buf_addr;
    assign buf_data   = r_buf_data;
    assign busy       = r_busy;
    assign cursor_col = r_cur_col;
    assign cursor_row = r_cur_row;
    assign err_drop   = r_err_drop;

endmodule

// File: tb/tb_vga_text_cmd_engine.sv
// Directed bench for vga_text_cmd_engine: character puts, cursor control,
// back-pressure, FIFO overflow, screen clear and mid-clear reset.
module tb_vga_text_cmd_engine;

    localparam int ADDR_W = 12;

    logic              ACLK;
    logic              ARESETN;
    logic              cfg_wr;
    logic [1:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic              buf_valid;
    logic              buf_ready;
    logic [ADDR_W-1:0] buf_addr;
    logic [15:0]       buf_data;
    logic              busy;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              err_drop;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int q_addr[$];
    int q_data[$];
    int q_cyc[$];

    vga_text_cmd_engine #(
        .COLS(80), .ROWS(30), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .buf_valid  (buf_valid),
        .buf_ready  (buf_ready),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .err_drop   (err_drop)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Record every accepted buffer write with the cycle it happened in.
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (ARESETN && buf_valid && buf_ready) begin
            q_addr.push_back(int'(buf_addr));
            q_data.push_back(int'(buf_data));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge ACLK);
        cfg_wr    = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i;
        for (i = 0; i < 20; i++) begin
            if (buf_valid) break;
            @(negedge ACLK);
        end
        chk({tag, "_to"}, 32'(i < 20), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        @(negedge ACLK);
        @(negedge ACLK);
        for (i = 0; i < budget; i++) begin
            if (!busy && !buf_valid) break;
            @(negedge ACLK);
        end
        chk({tag, "_to"}, 32'(i < budget), 32'd1);
    endtask

    initial begin
        int base;
        int bad;
        int first_bad;

        ARESETN   = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'd0;
        buf_ready = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_valid", 32'(buf_valid), 32'd0);
        chk("rst_addr",  32'(buf_addr),  32'd0);
        chk("rst_data",  32'(buf_data),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_col",   32'(cursor_col), 32'd0);
        chk("rst_row",   32'(cursor_row), 32'd0);
        chk("rst_err",   32'(err_drop),  32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Single PUT: valid exactly two cycles after the strobe.
        wr(2'd1, 32'h41);
        chk("lat_n1_valid", 32'(buf_valid), 32'd0);
        @(negedge ACLK);
        chk("lat_n2_valid", 32'(buf_valid), 32'd1);
        chk("put_addr",     32'(buf_addr),  32'd0);
        chk("put_data",     32'(buf_data),  32'h0741);
        @(negedge ACLK);
        chk("put_done",     32'(buf_valid), 32'd0);
        chk("put_col",      32'(cursor_col), 32'd1);
        chk("put_row",      32'(cursor_row), 32'd0);
        wait_idle("put_idle", 10);
        chk("put_busy",     32'(busy), 32'd0);

        // Bottom-right cell and full-screen wrap, then clamping.
        wr(2'd2, 32'h0000_1D4F);
        wr(2'd1, 32'h5A);
        wait_valid("wrap_v");
        chk("wrap_addr", 32'(buf_addr), 32'd2399);
        chk("wrap_data", 32'(buf_data), 32'h075A);
        @(negedge ACLK);
        chk("wrap_col",  32'(cursor_col), 32'd0);
        chk("wrap_row",  32'(cursor_row), 32'd0);
        wr(2'd2, 32'h0000_1F64);
        repeat (2) @(negedge ACLK);
        chk("clamp_col", 32'(cursor_col), 32'd79);
        chk("clamp_row", 32'(cursor_row), 32'd29);

        // Back-pressure: beat must hold steady while ready is low.
        buf_ready = 1'b0;
        base = q_addr.size();
        wr(2'd1, 32'h33);
        wait_valid("stall_v");
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            chk("stall_valid", 32'(buf_valid), 32'd1);
            chk("stall_addr",  32'(buf_addr),  32'd2399);
            chk("stall_data",  32'(buf_data),  32'h0733);
        end
        chk("stall_nowr", 32'(q_addr.size() - base), 32'd0);
        buf_ready = 1'b1;
        repeat (4) @(negedge ACLK);
        chk("stall_onewr", 32'(q_addr.size() - base), 32'd1);
        chk("stall_col",   32'(cursor_col), 32'd0);
        chk("stall_row",   32'(cursor_row), 32'd0);

        // FIFO overflow: six back-to-back CHARs with the buffer stalled.
        buf_ready = 1'b0;
        base = q_addr.size();
        for (int k = 0; k < 5; k++) wr(2'd1, 32'h61 + 32'(k));
        chk("ovf_err_pre", 32'(err_drop), 32'd0);
        wr(2'd1, 32'h66);
        chk("ovf_err",     32'(err_drop), 32'd1);
        chk("ovf_busy",    32'(busy),     32'd1);
        wr(2'd0, 32'h6);
        chk("ovf_err_clr", 32'(err_drop), 32'd0);
        buf_ready = 1'b1;
        wait_idle("ovf_idle", 40);
        chk("ovf_count", 32'(q_addr.size() - base), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < q_addr.size()) begin
                chk("ovf_addr", 32'(q_addr[base + k]), 32'(k));
                chk("ovf_data", 32'(q_data[base + k]), 32'h0761 + 32'(k));
            end
        end
        chk("ovf_col", 32'(cursor_col), 32'd5);

        // Clear screen with a new attribute; a CHAR written mid-clear follows it.
        wr(2'd3, 32'h1F);
        base = q_addr.size();
        wr(2'd0, 32'h3);
        repeat (100) @(negedge ACLK);
        wr(2'd1, 32'h42);
        wait_idle("clr_idle", 3000);
        chk("clr_count", 32'(q_addr.size() - base), 32'd2401);
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 2400 && base + k < q_addr.size(); k++) begin
            if (q_addr[base + k] != k || q_data[base + k] != 32'h1F20) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
        end
        chk("clr_bad_cells", 32'(bad), 32'd0);
        chk("clr_first_bad", 32'(first_bad), 32'hFFFF_FFFF);
        if (q_addr.size() >= base + 2401) begin
            chk("clr_span",  32'(q_cyc[base + 2399] - q_cyc[base]), 32'd2399);
            chk("clr_after_addr", 32'(q_addr[base + 2400]), 32'd0);
            chk("clr_after_data", 32'(q_data[base + 2400]), 32'h1F42);
        end
        chk("clr_col", 32'(cursor_col), 32'd1);
        chk("clr_row", 32'(cursor_row), 32'd0);

        // Auto-increment off: repeated writes hit the same cell.
        wr(2'd0, 32'h0);
        base = q_addr.size();
        for (int k = 0; k < 3; k++) wr(2'd1, 32'h71 + 32'(k));
        wait_idle("noinc_idle", 40);
        chk("noinc_count", 32'(q_addr.size() - base), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (base + k < q_addr.size()) begin
                chk("noinc_addr", 32'(q_addr[base + k]), 32'd1);
                chk("noinc_data", 32'(q_data[base + k]), 32'h1F71 + 32'(k));
            end
        end
        chk("noinc_col", 32'(cursor_col), 32'd1);

        // Reset in the middle of a clear.
        wr(2'd0, 32'h1);
        repeat (50) @(negedge ACLK);
        chk("mid_valid", 32'(buf_valid), 32'd1);
        chk("mid_data",  32'(buf_data),  32'h1F20);
        ARESETN = 1'b0;
        #1;
        chk("arst_valid", 32'(buf_valid), 32'd0);
        chk("arst_addr",  32'(buf_addr),  32'd0);
        chk("arst_data",  32'(buf_data),  32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_col",   32'(cursor_col), 32'd0);
        chk("arst_row",   32'(cursor_row), 32'd0);
        chk("arst_err",   32'(err_drop),  32'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("post_valid", 32'(buf_valid), 32'd0);
        wr(2'd1, 32'h41);
        wait_valid("post_v");
        chk("post_addr", 32'(buf_addr), 32'd0);
        chk("post_data", 32'(buf_data), 32'h0741);
        @(negedge ACLK);
        chk("post_col",  32'(cursor_col), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
